// File: rtl/regfile_dumper.sv
// regfile_dumper
// Walks a contiguous range of register-file indices and streams each register
// value out over a valid/ready handshake, accumulating a running checksum.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   start      dump request, only honoured while idle
//   first_idx  first register index to dump (sampled with start)
//   last_idx   last register index to dump, inclusive (sampled with start)
//   rf_addr    read address to the register file (combinational)
//   rf_data    read data for rf_addr, valid in the same cycle
//   out_valid  out_data/out_idx/out_last carry a word
//   out_ready  downstream accepts the word this cycle
//   out_data   register value
//   out_idx    register index of out_data
//   out_last   word is the final one of the dump
//   busy       dumper is not idle
//   done       one-cycle pulse once the final word has been accepted
//   err        one-cycle pulse when a start request with first > last is rejected
//   checksum   sum of all dumped words mod 2^32, held after the dump
module regfile_dumper #(
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IDXW-1:0] first_idx,
  input  logic [IDXW-1:0] last_idx,
  output logic [IDXW-1:0] rf_addr,
  input  logic [31:0]     rf_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [31:0]     checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] limit_q, limit_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     checksum_q, checksum_d;

  // While reset is held the read address and busy are forced low even before
  // the synchronous reset edge has cleared the registers.
  assign rf_addr   = rst ? cnt_q : '0;
  assign busy      = rst && (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = checksum_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    checksum_d  = checksum_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (first_idx <= last_idx) begin
            cnt_d      = first_idx;
            limit_d    = last_idx;
            checksum_d = '0;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        out_data_d  = rf_data;
        out_idx_d   = cnt_q;
        out_last_d  = (cnt_q == limit_q);
        checksum_d  = checksum_q + rf_data;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // The counter only advances when more words remain, so it stops
          // exactly on the limit and a full 0..31 dump cannot wrap.
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      limit_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      checksum_q  <= checksum_d;
    end
  end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 SHALL have parameter: IDXW, 5, register index width (32 architectural registers).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a dump; sampled only in IDLE.
REQ-005 SHALL have port: first_idx  input  5  first register index to dump; sampled with start.
REQ-006 SHALL have port: last_idx  input  5  last register index to dump, inclusive; sampled with start.
REQ-007 SHALL have port: rf_addr  output  5  read address to the register-file read port.
REQ-008 SHALL have port: rf_data  input  32  combinational read data for rf_addr, valid in the same cycle.
REQ-009 SHALL have port: out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-011 SHALL have port: out_data  output  32  register value.
REQ-012 SHALL have port: out_idx  output  5  index of the register in out_data.
REQ-013 SHALL have port: out_last  output  1  current word is the final word of the dump.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port: done  output  1  one-cycle pulse after the final word is accepted.
REQ-016 SHALL have port: err  output  1  one-cycle pulse when start is rejected.
REQ-017 SHALL have port: checksum  output  32  sum of all dumped words, mod 2^32; held after done.

Function
REQ-018 SHALL implement states IDLE, LOAD, SEND and DONE; all outputs registered except rf_addr.
REQ-019 SHALL drive rf_addr from the internal index counter in every state (IDLE: held value).
REQ-020 SHALL, in IDLE with start=1 and first_idx<=last_idx: load the counter with first_idx and last_idx into a limit register, clear checksum, and go to LOAD.
REQ-021 SHALL, in IDLE with start=1 and first_idx>last_idx: pulse err for one cycle, stay in IDLE, and leave checksum unchanged.
REQ-022 SHALL, in LOAD, register rf_data into out_data and the counter into out_idx, and set out_last=(counter==limit).
REQ-023 SHALL, in LOAD, add rf_data to checksum with wrap-around, set out_valid=1 on the next cycle, and go to SEND.
REQ-024 SHALL, in SEND, hold out_valid, out_data, out_idx and out_last stable while out_ready=0.
REQ-025 SHALL, in SEND with out_ready=1 and out_last=0: clear out_valid, increment the counter, and go to LOAD.
REQ-026 SHALL, in SEND with out_ready=1 and out_last=1: clear out_valid and go to DONE.
REQ-027 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-028 SHALL ignore start in any state other than IDLE.
REQ-029 SHALL sustain a throughput of one word per two cycles, and a single-register dump (first_idx==last_idx) SHALL emit exactly one word with out_last=1.
REQ-030 SHALL never increment the counter past the limit, so a dump of 0..31 SHALL end without wrapping to 0.
REQ-031 SHALL dump index 0 like any other index, with out_data equal to whatever rf_data returns (0 for x0).

Reset
REQ-032 SHALL, on a rising edge with rst=0, enter IDLE and clear out_valid, out_data, out_idx, out_last, done, err, checksum, the counter and the limit register.
REQ-033 SHALL let reset mid-dump abort immediately, with no done pulse and no further words emitted.
REQ-034 SHALL, while rst=0, drive busy=0 and rf_addr=0.

Verification
REQ-035 SHALL pass: start with first=1 and last=3, x1=5, x2=7, x3=0xFFFFFFFF, out_ready held at 1 -> words (1,5), (2,7) and (3,0xFFFFFFFF) are emitted; out_last is set only on idx 3; done pulses once; checksum=0x0000000B.
REQ-036 SHALL pass: out_ready held at 0 for 4 cycles during word idx 2 -> out_data and out_idx remain stable, and exactly 3 words are accepted in total.
REQ-037 SHALL pass: start with first=5 and last=2 -> err pulses for 1 cycle, busy stays 0, and no out_valid is raised.
REQ-038 SHALL pass: start with first=0 and last=31, ready always 1 -> 32 words with idx 0..31 are emitted, the first out_data is 0, the dump takes 64 cycles plus DONE, and the counter does not wrap.
REQ-039 SHALL pass: rst=0 asserted during SEND of idx 4 -> the next cycle shows out_valid=0, busy=0 and checksum=0, and no done pulse occurs.
REQ-040 SHALL pass: start pulsed again while busy -> it is ignored, and the original dump completes unchanged.
